// File: rtl/fancy_timer.sv
// -----------------------------------------------------------------------------
// fancy_timer
//
// Serial-programmed delay timer. While idle it watches `data` for PATTERN
// (MSB first, overlapping matches allowed). Once found, the next four bits are
// shifted in MSB-first as the delay value. The timer then runs for
// (delay+1) * TICKS_PER_UNIT cycles, decrementing `count` once per
// TICKS_PER_UNIT cycles, and finally raises `done` until `ack` is sampled.
//
// Parameters
//   TICKS_PER_UNIT  cycles per count unit (prescaler period, 2..1024)
//   PATTERN         4-bit start sequence, first bit = MSB
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high reset
//   data      in   serial start pattern / delay bits
//   ack       in   acknowledge of done
//   count     out  [3:0] remaining delay units
//   counting  out  high while the timer is running
//   done      out  high from expiry until acknowledged
// -----------------------------------------------------------------------------
module fancy_timer #(
  parameter int unsigned TICKS_PER_UNIT = 1000,
  parameter logic [3:0]  PATTERN        = 4'b1101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data,
  input  logic       ack,
  output logic [3:0] count,
  output logic       counting,
  output logic       done
);

  localparam int unsigned   PW      = $clog2(TICKS_PER_UNIT);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    match_q, match_d;   // longest PATTERN prefix currently matched
  logic [1:0]    shift_q, shift_d;   // delay bits shifted so far
  logic [3:0]    count_q, count_d;   // delay register / remaining units
  logic [PW-1:0] pre_q,   pre_d;     // prescaler
  logic [2:0]    match_next;

  // Overlap-aware prefix tracker: given k matched pattern bits and a new bit,
  // return the length of the longest pattern prefix that is a suffix of the
  // k+1 bits seen. A return of 4 means the whole pattern was just completed.
  function automatic logic [2:0] next_match(input logic [1:0] k, input logic b);
    int kk;
    int v;
    int res;
    kk  = int'(k);
    v   = ((int'(PATTERN) >> (4 - kk)) << 1) | int'(b);
    res = 0;
    for (int l = 4; l >= 1; l--) begin
      if (res == 0 && l <= kk + 1 &&
          ((v & ((1 << l) - 1)) == (int'(PATTERN) >> (4 - l)))) begin
        res = l;
      end
    end
    return 3'(res);
  endfunction

  assign match_next = next_match(match_q, data);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    shift_d = shift_q;
    count_d = count_q;
    pre_d   = pre_q;

    case (state_q)
      ST_SEARCH: begin
        if (match_next == 3'd4) begin
          state_d = ST_SHIFT;
          match_d = 2'd0;
          shift_d = 2'd0;
        end else begin
          match_d = match_next[1:0];
        end
      end

      ST_SHIFT: begin
        count_d = {count_q[2:0], data};
        shift_d = shift_q + 2'd1;
        if (shift_q == 2'd3) begin
          state_d = ST_COUNT;
          pre_d   = '0;
        end
      end

      ST_COUNT: begin
        // >= rather than == keeps a corrupted prescaler from running away.
        if (pre_q >= PRE_MAX) begin
          pre_d = '0;
          if (count_q == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q - 4'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      ST_DONE: begin
        count_d = 4'd0;
        pre_d   = '0;
        if (ack) begin
          state_d = ST_SEARCH;
          match_d = 2'd0;
        end
      end

      default: begin
        state_d = ST_SEARCH;
        match_d = 2'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      match_q <= 2'd0;
      shift_q <= 2'd0;
      count_q <= 4'd0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      shift_q <= shift_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end

  // Moore outputs, decoded from registered state only.
  assign count    = count_q;
  assign counting = (state_q == ST_COUNT);
  assign done     = (state_q == ST_DONE);

endmodule
